// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the front end and decode:
//   NOP_INSTR    - canonical bubble (addi x0, x0, 0)
//   if_state_e   - instruction-fetch FSM states
//   OPC_*        - major opcode constants used by decode
//   pc_plus4     - sequential next-PC helper (wraps mod 2^32)
//   opcode_of    - extracts the major opcode field of an instruction word
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } if_state_e;

    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [6:0] opcode_of(input logic [31:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/if_buf.sv
// -----------------------------------------------------------------------------
// if_buf
// One-entry hold buffer for a fetched instruction that arrives while decode
// is stalled.
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture load_data/load_addr, mark full
//   flush                 discard contents (wins over load and unload)
//   unload                contents consumed, mark empty
//   load_data, load_addr  instruction word and its address
//   data, addr, full      buffered word, its address, occupancy flag
// -----------------------------------------------------------------------------
module if_buf
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        unload,
    input  logic [31:0] load_data,
    input  logic [31:0] load_addr,
    output logic [31:0] data,
    output logic [31:0] addr,
    output logic        full
);

    logic [31:0] data_reg;
    logic [31:0] addr_reg;
    logic        full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= NOP_INSTR;
            addr_reg <= 32'd0;
            full_reg <= 1'b0;
        end else if (flush) begin
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= load_data;
            addr_reg <= load_addr;
            full_reg <= 1'b1;
        end else if (unload) begin
            full_reg <= 1'b0;
        end
    end

    assign data = data_reg;
    assign addr = addr_reg;
    assign full = full_reg;

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction fetch stage: one outstanding request to instruction memory,
// a one-entry hold buffer for decode stalls, and redirect handling that drains
// a stale in-flight request before fetching the new target.
//
// Parameters
//   RESET_PC        first fetch address after reset
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   hold            decode stall; freezes instr/pc_if2id/instr_valid
//   redirect        taken branch / jump from execute (highest priority)
//   redirect_pc     redirect target
//   imem_req        memory request, registered
//   imem_addr       memory request address, registered
//   imem_rvalid     memory read data valid
//   imem_rdata      memory read data
//   instr           instruction to decode (NOP when not valid)
//   pc_if2id        address of instr
//   instr_valid     instr holds a real fetched word
//   fetch_misalign  (only with IFETCH_MISALIGN_TRAP_EN) misaligned redirect
//                   seen; fetch halted until reset
//
// Build option: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets; otherwise the low two target bits are forced to zero.
//
// Memory model assumed: the request presented in a cycle is accepted by the
// memory; rvalid may come back in that same cycle (zero-wait) or later.
// While a request is outstanding, imem_req/imem_addr do not change.
// -----------------------------------------------------------------------------
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_if2id,
    output logic        instr_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    if_state_e   state_reg,  state_next;
    logic        req_reg,    req_next;
    logic [31:0] addr_reg,   addr_next;
    logic [31:0] instr_reg,  instr_next;
    logic [31:0] pc_reg,     pc_next;
    logic        valid_reg,  valid_next;

    logic        buf_load;
    logic        buf_flush;
    logic        buf_unload;
    logic [31:0] buf_data;
    logic [31:0] buf_addr;
    logic        buf_full;

    logic [31:0] redirect_target;
    logic        redirect_bad;
    logic        req_in_flight;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_reg, misalign_next;

    assign redirect_target = redirect_pc;
    assign redirect_bad    = |redirect_pc[1:0];
`else
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign redirect_bad    = 1'b0;
`endif

    // In RUN the request line is only low for the single cycle after reset,
    // so a raised request in RUN means the memory owes us a response.
    assign req_in_flight = (state_reg == ST_RUN) && req_reg;

    if_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .flush     (buf_flush),
        .unload    (buf_unload),
        .load_data (imem_rdata),
        .load_addr (addr_reg),
        .data      (buf_data),
        .addr      (buf_addr),
        .full      (buf_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            req_reg   <= 1'b0;
            addr_reg  <= RESET_PC;
            instr_reg <= NOP_INSTR;
            pc_reg    <= 32'd0;
            valid_reg <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
            instr_reg <= instr_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        buf_unload = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misalign_next = misalign_reg;
`endif

        if (redirect && (state_reg != ST_HALT)) begin
            // Redirect overrides hold and any returning data.
            buf_flush  = 1'b1;
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            if (redirect_bad) begin
                state_next = ST_HALT;
                req_next   = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                misalign_next = 1'b1;
`endif
            end else begin
                addr_next = redirect_target;
                // A response still owed for the old path must be swallowed
                // before the new target can be requested. Data returning in
                // this very cycle is simply dropped instead.
                if ((req_in_flight || (state_reg == ST_DRAIN)) && !imem_rvalid) begin
                    state_next = ST_DRAIN;
                    req_next   = 1'b0;
                end else begin
                    state_next = ST_RUN;
                    req_next   = 1'b1;
                end
            end
        end else begin
            unique case (state_reg)
                ST_RUN: begin
                    if (req_reg && imem_rvalid) begin
                        if (hold) begin
                            buf_load   = 1'b1;
                            req_next   = 1'b0;
                            state_next = ST_HELD;
                        end else begin
                            instr_next = imem_rdata;
                            pc_next    = addr_reg;
                            valid_next = 1'b1;
                            addr_next  = pc_plus4(addr_reg);
                        end
                    end else begin
                        // No data this cycle (or a late response after
                        // reset while the request line was still low).
                        if (!hold) begin
                            instr_next = NOP_INSTR;
                            valid_next = 1'b0;
                        end
                        req_next = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!hold) begin
                        if (buf_full) begin
                            instr_next = buf_data;
                            pc_next    = buf_addr;
                            valid_next = 1'b1;
                            buf_unload = 1'b1;
                        end
                        addr_next  = pc_plus4(addr_reg);
                        req_next   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // imem_addr already holds the latest redirect target.
                    if (imem_rvalid) begin
                        req_next   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign instr       = instr_reg;
    assign pc_if2id    = pc_reg;
    assign instr_valid = valid_reg;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Directed scenarios followed by a randomized phase. A memory model with
// random latency answers requests; a program-order scoreboard tracks which
// address decode must see next (sequential +4, jumping to the target after
// each redirect) and checks every delivered word against memory contents.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] pc_if2id;
    logic        instr_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc_if2id    (pc_if2id),
        .instr_valid (instr_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int delivered = 0;

    // memory model state
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          cnt = 0;
    int          lat_max = 0;
    int          lat_force = -1;

    // scoreboard
    logic [31:0] exp_pc = RESET_PC;
    logic        hold_p, redir_p, rvalid_p, req_p, pend_after, valid_p;
    logic [31:0] rpc_p, instr_p, pc_p;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_8133;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0513;
        endcase
    endfunction

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decide this cycle's memory response from the request currently shown.
    task automatic mem_drive();
        if (!pend && imem_req) begin
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = (lat_force >= 0) ? lat_force : int'($urandom_range(0, lat_max));
            lat_force = -1;
        end else if (pend && imem_req) begin
            check("addr_stable", imem_addr, paddr);
        end
        if (pend && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) cnt--;
        end
    endtask

    task automatic scoreboard();
        if (!instr_valid) check("nop_when_invalid", instr, NOP);
        if (redir_p) begin
            if (!TRAP_EN || rpc_p[1:0] == 2'b00) begin
                check("redir_bubble", 32'(instr_valid), 32'd0);
                check("redir_addr", imem_addr, align4(rpc_p));
                check("redir_req", 32'(imem_req), 32'(!pend_after));
                exp_pc = align4(rpc_p);
            end
        end else if (hold_p) begin
            check("hold_instr", instr, instr_p);
            check("hold_pc", pc_if2id, pc_p);
            check("hold_valid", 32'(instr_valid), 32'(valid_p));
            if (rvalid_p && req_p) check("hold_drop_req", 32'(imem_req), 32'd0);
        end else if (instr_valid) begin
            check("sb_pc", pc_if2id, exp_pc);
            check("sb_instr", instr, mem_word(exp_pc));
            $display("[TB] fetch pc=%h instr=%h", pc_if2id, instr);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass,
    // then check the outputs at the next falling edge.
    task automatic step(input logic h, input logic r, input logic [31:0] rpc);
        hold        = h;
        redirect    = r;
        redirect_pc = rpc;
        mem_drive();
        hold_p     = h;
        redir_p    = r;
        rpc_p      = rpc;
        rvalid_p   = imem_rvalid;
        req_p      = imem_req;
        pend_after = pend;
        instr_p    = instr;
        pc_p       = pc_if2id;
        valid_p    = instr_valid;
        @(negedge clk);
        scoreboard();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_instr"}, instr, NOP);
        check({tag, "_pc"}, pc_if2id, 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check({tag, "_misalign"}, 32'(fetch_misalign), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n  = 1'b1;
        pend   = 1'b0;
        exp_pc = RESET_PC;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // Reset release and zero-wait streaming
        lat_max = 0;
        step(1'b0, 1'b0, 32'd0);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'd0);
        check("w0_instr", instr, 32'h00A0_0093);
        check("w0_pc", pc_if2id, 32'h0);
        check("w0_valid", 32'(instr_valid), 32'd1);
        step(1'b0, 1'b0, 32'd0);
        check("w1_instr", instr, 32'h0010_0113);
        check("w1_pc", pc_if2id, 32'h4);

        // Hold for three cycles while the word at 0x8 returns
        step(1'b1, 1'b0, 32'd0);
        check("held_req", 32'(imem_req), 32'd0);
        check("held_instr", instr, 32'h0010_0113);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("held_req3", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("unheld_instr", instr, 32'h0020_8133);
        check("unheld_pc", pc_if2id, 32'h8);
        check("resume_addr", imem_addr, 32'hC);
        check("resume_req", 32'(imem_req), 32'd1);
        step(1'b0, 1'b0, 32'd0);
        check("resume_pc", pc_if2id, 32'hC);

        // Redirect while the request at 0x10 is outstanding
        lat_force = 2;
        step(1'b0, 1'b0, 32'd0);
        check("late_bubble", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b1, 32'h100);
        check("drain_req", 32'(imem_req), 32'd0);
        check("drain_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        check("stale_dropped", 32'(instr_valid), 32'd0);
        check("post_drain_req", 32'(imem_req), 32'd1);
        step(1'b0, 1'b0, 32'd0);
        check("target_pc", pc_if2id, 32'h100);
        check("target_valid", 32'(instr_valid), 32'd1);

        // Redirect and hold together with returning data
        step(1'b1, 1'b1, 32'h200);
        check("rhr_addr", imem_addr, 32'h200);
        check("rhr_req", 32'(imem_req), 32'd1);
        check("rhr_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("rhr_pc", pc_if2id, 32'h200);

        // Asynchronous reset in the middle of a request at 0x20
        step(1'b0, 1'b1, 32'h20);
        lat_force = 3;
        step(1'b0, 1'b0, 32'd0);
        check("mid_addr", imem_addr, 32'h20);
        check("mid_req", 32'(imem_req), 32'd1);
        #3;
        rst_n       = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        cnt    = 0;          // the old request's data turns up right after reset
        exp_pc = RESET_PC;
        step(1'b0, 1'b0, 32'd0);
        check("late_rvalid_dropped", 32'(instr_valid), 32'd0);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'd0);
        check("restart_instr", instr, 32'h00A0_0093);
        check("restart_pc", pc_if2id, RESET_PC);

        // Misaligned redirect target
        step(1'b0, 1'b1, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("trap_flag", 32'(fetch_misalign), 32'd1);
        check("trap_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("halt_req", 32'(imem_req), 32'd0);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_flag", 32'(fetch_misalign), 32'd1);
`else
        check("misalign_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        check("misalign_pc", pc_if2id, 32'h100);
`endif

        // Randomized phase
        do_reset();
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            logic        h;
            logic        r;
            logic [31:0] rpc;
            h   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 11) == 0);
            rpc = $urandom & 32'h0000_03FC;
            if (!TRAP_EN && $urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            step(h, r, rpc);
        end
        check("progress", 32'(delivered >= 60), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
